// File: rtl/pong_game_ctrl_if.sv
// Pong controller signal bundle.
// Purpose: groups the key, miss and timer inputs and the game-state outputs of pong_game_ctrl.
// Modports:
//   master - the surroundings: drive keys, misses and timer_up; observe the game outputs.
//   slave  - the controller: the reverse directions.
// Parameter SCORE_W sets the width of score_l / score_r.
interface pong_game_ctrl_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               key_start;
    logic               key_pause;
    logic               miss_left;
    logic               miss_right;
    logic               timer_up;
    logic               timer_start;
    logic               ball_en;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               game_over;
    logic               winner;
    logic [2:0]         state;

    modport master (
        output key_start, key_pause, miss_left, miss_right, timer_up,
        input  timer_start, ball_en, ball_reset, serve_dir, score_l, score_r,
               game_over, winner, state
    );

    modport slave (
        input  key_start, key_pause, miss_left, miss_right, timer_up,
        output timer_start, ball_en, ball_reset, serve_dir, score_l, score_r,
               game_over, winner, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller.
// Purpose: sequences IDLE -> NEWBALL (serve delay) -> PLAY <-> PAUSE -> GAMEOVER, keeps both
// scores, pulses the new-ball timer reload and gates the ball-motion logic.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - pong_game_ctrl_if.slave: key_start/key_pause/miss_left/miss_right/timer_up in;
//          timer_start, ball_en, ball_reset, serve_dir, score_l, score_r, game_over,
//          winner, state out.
// Parameters: WIN_SCORE (score that ends the game), SCORE_W (score register width; must
// match the interface's SCORE_W).
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE = 9,
    parameter int unsigned SCORE_W   = 4
) (
    input logic              clk,
    input logic              rst,
    pong_game_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StNewBall  = 3'd1,
        StPlay     = 3'd2,
        StPause    = 3'd3,
        StGameOver = 3'd4
    } state_e;

    localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ScoreOne = SCORE_W'(1);

    state_e             state_q;
    logic [SCORE_W-1:0] score_l_q;
    logic [SCORE_W-1:0] score_r_q;
    logic               serve_dir_q;
    logic               winner_q;
    logic               timer_start_q;

    logic [SCORE_W-1:0] score_l_inc;
    logic [SCORE_W-1:0] score_r_inc;

    assign score_l_inc = score_l_q + ScoreOne;
    assign score_r_inc = score_r_q + ScoreOne;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            score_l_q     <= '0;
            score_r_q     <= '0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            timer_start_q <= 1'b0;
        end else begin
            // Reload pulse lasts only the first NEWBALL cycle.
            timer_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.key_start) begin
                        score_l_q     <= '0;
                        score_r_q     <= '0;
                        state_q       <= StNewBall;
                        timer_start_q <= 1'b1;
                    end
                end
                StNewBall: begin
                    // timer_up is stale while the reload pulse is out; ignore it then.
                    if (bus.timer_up && !timer_start_q) begin
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    if (bus.miss_left) begin
                        score_r_q   <= score_r_inc;
                        serve_dir_q <= 1'b0;
                        if (score_r_inc == WinScore) begin
                            state_q  <= StGameOver;
                            winner_q <= 1'b1;
                        end else begin
                            state_q       <= StNewBall;
                            timer_start_q <= 1'b1;
                        end
                    end else if (bus.miss_right) begin
                        score_l_q   <= score_l_inc;
                        serve_dir_q <= 1'b1;
                        if (score_l_inc == WinScore) begin
                            state_q  <= StGameOver;
                            winner_q <= 1'b0;
                        end else begin
                            state_q       <= StNewBall;
                            timer_start_q <= 1'b1;
                        end
                    end else if (bus.key_pause) begin
                        state_q <= StPause;
                    end
                end
                StPause: begin
                    if (bus.key_pause) begin
                        state_q <= StPlay;
                    end
                end
                StGameOver: begin
                    if (bus.key_start) begin
                        score_l_q     <= '0;
                        score_r_q     <= '0;
                        winner_q      <= 1'b0;
                        state_q       <= StNewBall;
                        timer_start_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Moore decode from the state register only.
    assign bus.ball_en     = (state_q == StPlay);
    assign bus.ball_reset  = (state_q == StIdle) || (state_q == StNewBall) ||
                             (state_q == StGameOver);
    assign bus.game_over   = (state_q == StGameOver);
    assign bus.state       = state_q;
    assign bus.timer_start = timer_start_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.winner      = winner_q;
    assign bus.score_l     = score_l_q;
    assign bus.score_r     = score_r_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: expectations are queued alongside each stimulus step and
// drained against the DUT outputs #1 after the following clock edge.
module tb_pong_game_ctrl;
    localparam int SelState  = 0;
    localparam int SelScoreL = 1;
    localparam int SelScoreR = 2;
    localparam int SelTStart = 3;
    localparam int SelBallEn = 4;
    localparam int SelBallRs = 5;
    localparam int SelServe  = 6;
    localparam int SelGOver  = 7;
    localparam int SelWinner = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    pong_game_ctrl_if #(.SCORE_W(4)) bus ();

    pong_game_ctrl #(.WIN_SCORE(9), .SCORE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SelState:  return {13'd0, bus.state};
            SelScoreL: return {12'd0, bus.score_l};
            SelScoreR: return {12'd0, bus.score_r};
            SelTStart: return {15'd0, bus.timer_start};
            SelBallEn: return {15'd0, bus.ball_en};
            SelBallRs: return {15'd0, bus.ball_reset};
            SelServe:  return {15'd0, bus.serve_dir};
            SelGOver:  return {15'd0, bus.game_over};
            SelWinner: return {15'd0, bus.winner};
            default:   return 16'hdead;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance one clock, release one-cycle pulses, then compare queued expectations.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.key_start  = 1'b0;
        bus.key_pause  = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        drain();
    endtask

    // From NEWBALL with the reload pulse already gone: expire the timer and enter PLAY.
    task automatic serve(input string tag);
        bus.timer_up = 1'b1;
        push(tag, SelState, 16'd2);
        tick();
        bus.timer_up = 1'b0;
    endtask

    // From PLAY: one miss that does not end the game, then serve again.
    task automatic point(input logic left_miss, input int new_score);
        bus.miss_left  = left_miss;
        bus.miss_right = ~left_miss;
        push("pt_state", SelState, 16'd1);
        push("pt_ts", SelTStart, 16'd1);
        if (left_miss) push("pt_score_r", SelScoreR, 16'(new_score));
        else           push("pt_score_l", SelScoreL, 16'(new_score));
        tick();
        tick();
        serve("pt_serve");
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.key_start  = 1'b0;
        bus.key_pause  = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        bus.timer_up   = 1'b0;

        // Reset state.
        push("rst_state", SelState, 16'd0);
        push("rst_score_l", SelScoreL, 16'd0);
        push("rst_score_r", SelScoreR, 16'd0);
        push("rst_ts", SelTStart, 16'd0);
        push("rst_ball_en", SelBallEn, 16'd0);
        push("rst_ball_rs", SelBallRs, 16'd1);
        push("rst_serve", SelServe, 16'd0);
        push("rst_gover", SelGOver, 16'd0);
        push("rst_winner", SelWinner, 16'd0);
        tick();
        tick();
        rst = 1'b0;

        // Start: NEWBALL with reload pulse; stale timer_up in entry cycle must not release.
        bus.key_start = 1'b1;
        push("start_state", SelState, 16'd1);
        push("start_ts", SelTStart, 16'd1);
        push("start_ball_rs", SelBallRs, 16'd1);
        tick();
        bus.timer_up = 1'b1;
        push("stale_state", SelState, 16'd1);
        push("stale_ts", SelTStart, 16'd0);
        tick();
        bus.timer_up = 1'b0;
        push("wait_state", SelState, 16'd1);
        tick();
        tick();
        push("play_ball_en", SelBallEn, 16'd1);
        push("play_ball_rs", SelBallRs, 16'd0);
        serve("first_serve");

        // Miss on each side.
        bus.miss_right = 1'b1;
        push("mr_score_l", SelScoreL, 16'd1);
        push("mr_serve", SelServe, 16'd1);
        push("mr_state", SelState, 16'd1);
        push("mr_ts", SelTStart, 16'd1);
        tick();
        push("mr_ts_clear", SelTStart, 16'd0);
        tick();
        serve("mr_serve2");
        bus.miss_left = 1'b1;
        push("ml_score_r", SelScoreR, 16'd1);
        push("ml_serve", SelServe, 16'd0);
        push("ml_state", SelState, 16'd1);
        push("ml_ts", SelTStart, 16'd1);
        tick();
        tick();
        serve("ml_serve2");

        // Left player runs to the win.
        for (int s = 2; s <= 8; s++) point(1'b0, s);
        bus.miss_right = 1'b1;
        push("lwin_score_l", SelScoreL, 16'd9);
        push("lwin_state", SelState, 16'd4);
        push("lwin_gover", SelGOver, 16'd1);
        push("lwin_winner", SelWinner, 16'd0);
        push("lwin_ball_rs", SelBallRs, 16'd1);
        push("lwin_ts", SelTStart, 16'd0);
        tick();
        bus.key_start = 1'b1;
        push("restart_state", SelState, 16'd1);
        push("restart_score_l", SelScoreL, 16'd0);
        push("restart_score_r", SelScoreR, 16'd0);
        push("restart_ts", SelTStart, 16'd1);
        push("restart_gover", SelGOver, 16'd0);
        tick();
        tick();
        serve("restart_serve");

        // Pause: misses and start are ignored until resume.
        bus.key_pause = 1'b1;
        push("pause_state", SelState, 16'd3);
        push("pause_ball_en", SelBallEn, 16'd0);
        push("pause_ball_rs", SelBallRs, 16'd0);
        tick();
        bus.miss_left = 1'b1;
        bus.key_start = 1'b1;
        push("pause_hold_state", SelState, 16'd3);
        push("pause_hold_score_r", SelScoreR, 16'd0);
        tick();
        bus.key_pause = 1'b1;
        push("resume_state", SelState, 16'd2);
        tick();

        // Simultaneous inputs: miss_left wins.
        bus.miss_left  = 1'b1;
        bus.miss_right = 1'b1;
        bus.key_pause  = 1'b1;
        push("prio_score_r", SelScoreR, 16'd1);
        push("prio_score_l", SelScoreL, 16'd0);
        push("prio_state", SelState, 16'd1);
        push("prio_serve", SelServe, 16'd0);
        tick();
        tick();
        serve("prio_serve2");

        // Right player runs to the win; key_pause ignored in GAMEOVER.
        for (int s = 2; s <= 8; s++) point(1'b1, s);
        bus.miss_left = 1'b1;
        push("rwin_score_r", SelScoreR, 16'd9);
        push("rwin_state", SelState, 16'd4);
        push("rwin_winner", SelWinner, 16'd1);
        tick();
        bus.key_pause = 1'b1;
        push("go_pause_state", SelState, 16'd4);
        tick();
        bus.key_start = 1'b1;
        push("rrestart_winner", SelWinner, 16'd0);
        push("rrestart_score_r", SelScoreR, 16'd0);
        push("rrestart_state", SelState, 16'd1);
        tick();
        tick();
        serve("rrestart_serve");

        // Asynchronous reset mid-NEWBALL with score_r = 5 and reload pulse high.
        for (int s = 1; s <= 4; s++) point(1'b1, s);
        bus.miss_left = 1'b1;
        push("pre_rst_score_r", SelScoreR, 16'd5);
        push("pre_rst_ts", SelTStart, 16'd1);
        tick();
        #3;
        rst = 1'b1;
        #1;
        push("arst_state", SelState, 16'd0);
        push("arst_score_r", SelScoreR, 16'd0);
        push("arst_ball_rs", SelBallRs, 16'd1);
        push("arst_ts", SelTStart, 16'd0);
        drain();
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level Pong game-state controller, directly downstream of the two-second new-ball timer. Sequences idle, serve delay, play, pause and game-over. Issues the timer's start pulse and consumes its `timer_up` flag to release each new ball. Keeps both players' scores and gates the ball-motion logic.

## Interface
Parameters:
- `WIN_SCORE`, default 9: score that ends the game. Must satisfy 1 ≤ WIN_SCORE ≤ 2^SCORE_W−1.
- `SCORE_W`, default 4: width of each score register.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_start` in 1: one-cycle debounced start/restart pulse.
- `key_pause` in 1: one-cycle debounced pause/resume pulse.
- `miss_left` in 1: one-cycle pulse; ball exited the left edge, so the right player scores.
- `miss_right` in 1: one-cycle pulse; ball exited the right edge, so the left player scores.
- `timer_up` in 1: high while the new-ball timer is expired (count = 0).
- `timer_start` out 1: registered one-cycle pulse that reloads the new-ball timer.
- `ball_en` out 1: ball may move (state PLAY only).
- `ball_reset` out 1: hold the ball at centre (states IDLE, NEWBALL, GAMEOVER).
- `serve_dir` out 1: direction of the next serve (0 = toward left, 1 = toward right).
- `score_l` out SCORE_W: left player score.
- `score_r` out SCORE_W: right player score.
- `game_over` out 1: high in GAMEOVER.
- `winner` out 1: 0 = left won, 1 = right won; valid while `game_over`.
- `state` out 3: state code for debug/HUD (IDLE=0, NEWBALL=1, PLAY=2, PAUSE=3, GAMEOVER=4).

## Operation
- Reset values: state IDLE, `score_l`=`score_r`=0, `timer_start`=0, `ball_en`=0, `ball_reset`=1, `serve_dir`=0, `game_over`=0, `winner`=0.
- IDLE
  - `key_start`: clear both scores, go to NEWBALL.
- NEWBALL
  - `ball_reset`=1, `ball_en`=0.
  - Leave for PLAY when `timer_up`=1 and `timer_start`=0. The entry cycle is never a release cycle, because `timer_up` is still stale there.
- PLAY
  - `ball_en`=1, `ball_reset`=0.
  - `miss_left`: `score_r`+1, `serve_dir`←0.
  - `miss_right`: `score_l`+1, `serve_dir`←1.
  - If the incremented score equals WIN_SCORE: go to GAMEOVER and latch `winner` (1 if right scored). Otherwise go to NEWBALL.
  - `key_pause` with no miss pending: go to PAUSE.
- PAUSE
  - `ball_en`=0, `ball_reset`=0; ball position held.
  - `key_pause`: back to PLAY. `key_start` ignored.
- GAMEOVER
  - `game_over`=1, `ball_reset`=1.
  - `key_start`: clear scores and `winner`, go to NEWBALL.
- Every transition into NEWBALL (from IDLE, PLAY or GAMEOVER) asserts `timer_start` for exactly the first cycle in NEWBALL.
- Priority in PLAY, same cycle: `miss_left` > `miss_right` > `key_pause`. Lower-priority inputs are dropped, not queued.
- Inputs are ignored outside their listed states: misses outside PLAY, `key_pause` outside PLAY/PAUSE, `key_start` in NEWBALL/PLAY/PAUSE.
- Score arithmetic is unsigned SCORE_W-bit. Scores never exceed WIN_SCORE, so no wrap is possible.

## Timing
- State, scores, `serve_dir`, `winner` and `timer_start` are registered and update on the `clk` rising edge.
- `ball_en`, `ball_reset`, `game_over` and `state` decode from the state register only (Moore). No input-to-output combinational path.
- Input pulse sampled at edge N:
  - State and score change visible in cycle N+1.
  - `timer_start`=1 in cycle N+1 when entering NEWBALL.
- The timer reloads at the end of cycle N+1, so `timer_up`=0 from N+2.
- Serve delay: PLAY is entered one cycle after the timer expires, about 127 `timer_tick` periods after `timer_start`.
- `rst` asserted in any state: all outputs take their reset values immediately, with no clock needed. An in-progress serve delay is abandoned; the timer is restarted by the next NEWBALL entry.
- Releasing `rst` while `key_start` is high: that pulse is not acted on until the first edge after release.

## Test plan
- Reset, then `key_start`:
  - Next cycle: state=1, `timer_start`=1 for one cycle, scores 0.
  - Hold `timer_up`=1 through the entry cycle: no PLAY. Drop `timer_up` next cycle, raise it later: state=2 one cycle after the rise.
- In PLAY, `miss_right`: `score_l`=1, `serve_dir`=1, state=1, `timer_start` pulse. Repeat with `miss_left`: `score_r`=1, `serve_dir`=0.
- Drive `score_l` to 8, then `miss_right`: `score_l`=9, state=4, `game_over`=1, `winner`=0, `ball_reset`=1. `key_start` → scores 0, `winner`=0, state=1.
- PLAY: `key_pause` → state=3, `ball_en`=0. Then `miss_left` and `key_start` → no change. `key_pause` → state=2.
- Same cycle `miss_left`+`miss_right`+`key_pause` in PLAY → only `score_r` increments, state=1.
- Assert `rst` mid-NEWBALL with `score_r`=5 → immediately state=0, scores 0, `ball_reset`=1, `timer_start`=0.
